// File: rtl/filter_output_bram.sv
// ---------------------------------------------------------------------------
// filter_output_bram
//
// Captures a fixed-length burst of FIR filter outputs into a block RAM.
// Each accepted sample is rounded and shifted down to OUT_WIDTH bits, clamped
// to the signed output range, and written at the next free address. A
// separate synchronous read port lets software fetch the stored samples at
// any time.
//
// Parameters
//   IN_WIDTH   signed width of the incoming filter accumulator
//   OUT_WIDTH  signed width of each stored sample
//   SHIFT      right shift applied after rounding (0 .. IN_WIDTH-1)
//   OUT_DEPTH  memory depth
//   OUT_LEN    samples per capture (1 .. OUT_DEPTH)
//   LEN        address / counter width
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset (memory contents kept)
//   i_start      arm a capture from IDLE or DONE (ignored while capturing)
//   i_clear      abort / restart: back to IDLE, counters and flags zeroed
//   i_fir_valid  i_fir_dat holds a valid filter output this cycle
//   i_fir_dat    signed filter output
//   i_rd_en      readback request
//   i_rd_addr    readback address
//   o_rd_data    readback data, one cycle after i_rd_en (0 when out of range)
//   o_rd_valid   i_rd_en delayed by one cycle
//   o_busy       capture in progress
//   o_cap_comp   capture complete, held until start/clear/reset
//   o_sat        sticky: a stored sample of this capture was clamped
//   o_ovf        sticky: a sample arrived after the capture was full
//   o_count      samples written in the current capture
// ---------------------------------------------------------------------------
module filter_output_bram #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int OUT_DEPTH = 101,
  parameter int OUT_LEN   = 100,
  parameter int LEN       = $clog2(OUT_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic                 i_fir_valid,
  input  logic [IN_WIDTH-1:0]  i_fir_dat,
  input  logic                 i_rd_en,
  input  logic [LEN-1:0]       i_rd_addr,
  output logic [OUT_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_busy,
  output logic                 o_cap_comp,
  output logic                 o_sat,
  output logic                 o_ovf,
  output logic [LEN-1:0]       o_count
);

  // One extra bit of headroom so the rounding add can never wrap.
  localparam int XW = IN_WIDTH + 1;
  localparam logic        [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] ROUND_C = (ONE_X << SHIFT) >> 1;
  localparam logic signed [XW-1:0] SAT_MAX = (ONE_X << (OUT_WIDTH - 1)) - ONE_X;
  localparam logic signed [XW-1:0] SAT_MIN = XW'(0) - (ONE_X << (OUT_WIDTH - 1));
  localparam logic [LEN-1:0] CAP_LEN  = LEN'(OUT_LEN);
  localparam logic [LEN-1:0] LAST_IDX = LEN'(OUT_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t state_q, state_d;

  logic                  s1_valid_q;
  logic [OUT_WIDTH-1:0]  s1_data_q;
  logic                  s1_sat_q;
  logic [LEN-1:0]        count_q;
  logic                  sat_q;
  logic                  ovf_q;
  logic                  cap_comp_q;

  logic signed [XW-1:0]  ext_x;
  logic signed [XW-1:0]  rounded_x;
  logic signed [XW-1:0]  shifted_x;
  logic [OUT_WIDTH-1:0]  conv_dat;
  logic                  conv_sat;

  logic start_ok;
  logic accept;
  logic wr_en;
  logic drop;
  logic last_wr;

  logic [OUT_WIDTH-1:0] mem [0:OUT_DEPTH-1];
  logic [OUT_WIDTH-1:0] rd_raw_q;
  logic                 rd_zero_q;
  logic                 rd_valid_q;

  // Round-half-up, arithmetic shift, then clamp to the signed output range.
  always_comb begin
    ext_x     = $signed({i_fir_dat[IN_WIDTH-1], i_fir_dat});
    rounded_x = ext_x + ROUND_C;
    shifted_x = rounded_x >>> SHIFT;
    conv_sat  = 1'b0;
    conv_dat  = shifted_x[OUT_WIDTH-1:0];
    if (shifted_x > SAT_MAX) begin
      conv_dat = SAT_MAX[OUT_WIDTH-1:0];
      conv_sat = 1'b1;
    end else if (shifted_x < SAT_MIN) begin
      conv_dat = SAT_MIN[OUT_WIDTH-1:0];
      conv_sat = 1'b1;
    end
  end

  // Pipeline control. A held stage-1 sample is only written while there is
  // room left in the capture; anything beyond that is dropped and flagged.
  always_comb begin
    start_ok = i_start && (state_q != CAPTURE);
    accept   = i_fir_valid && (state_q == CAPTURE);
    wr_en    = s1_valid_q && !i_clear && (count_q < CAP_LEN);
    drop     = s1_valid_q && !i_clear && !(count_q < CAP_LEN);
    last_wr  = wr_en && (count_q == LAST_IDX);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear wins over everything else.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start) state_d = CAPTURE;
        CAPTURE: if (last_wr) state_d = DONE;
        DONE:    if (i_start) state_d = CAPTURE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage-1 payload; qualified by s1_valid_q so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_data_q <= conv_dat;
      s1_sat_q  <= conv_sat;
    end
  end

  // Counters and sticky status. The completion flag follows DONE by one
  // cycle so it rises the cycle after the final write has landed.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      s1_valid_q <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cap_comp_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (start_ok) begin
        count_q    <= '0;
        sat_q      <= 1'b0;
        ovf_q      <= 1'b0;
        cap_comp_q <= 1'b0;
      end else begin
        if (wr_en) begin
          count_q <= count_q + 1'b1;
        end
        if (wr_en && s1_sat_q) begin
          sat_q <= 1'b1;
        end
        if (drop || ((state_q == DONE) && i_fir_valid)) begin
          ovf_q <= 1'b1;
        end
        if (state_q == DONE) begin
          cap_comp_q <= 1'b1;
        end
      end
    end
  end

  // Write port: plain BRAM write, contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[count_q] <= s1_data_q;
    end
  end

  // Read port: registered read with enable, no reset, so it maps to BRAM.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      rd_raw_q <= mem[i_rd_addr];
    end
  end

  // Read qualifiers: out-of-range addresses and reset force the data to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= i_rd_en;
      if (i_rd_en) begin
        rd_zero_q <= (i_rd_addr >= CAP_LEN);
      end
    end
  end

  assign o_rd_data  = rd_zero_q ? '0 : rd_raw_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = (state_q == CAPTURE);
  assign o_cap_comp = cap_comp_q;
  assign o_sat      = sat_q;
  assign o_ovf      = ovf_q;
  assign o_count    = count_q;

endmodule
